// File: rtl/req_grant_requester.sv
// Requester side of a single-cycle req/grant payload interface. One token is
// outstanding at a time. Granted payloads are queued with their tags in a
// small result FIFO that feeds a valid/ready consumer.
module req_grant_requester #(
    parameter int unsigned payload_width  = 32,
    parameter int unsigned tag_width      = 4,
    parameter int unsigned fifo_depth     = 4,  // power of two, 2..16
    parameter int unsigned timeout_cycles = 16  // >= 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     issue_valid_i,
    input  logic [tag_width-1:0]     issue_tag_i,
    output logic                     issue_ready_o,
    input  logic                     flush_i,
    output logic                     req_o,
    input  logic                     grant_i,
    input  logic [payload_width-1:0] payload_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [payload_width-1:0] m_payload_o,
    output logic [tag_width-1:0]     m_tag_o,
    output logic                     busy_o,
    output logic                     wait_timeout_o
);

    localparam int unsigned AddrW = $clog2(fifo_depth);
    localparam int unsigned PtrW  = AddrW + 1;
    localparam int unsigned CntW  = $clog2(timeout_cycles + 1);

    localparam logic [CntW-1:0] WaitMax = CntW'(timeout_cycles);

    typedef enum logic {StIdle, StReq} state_e;

    state_e               state_q;
    logic                 req_q;
    logic [tag_width-1:0] tag_q;
    logic [CntW-1:0]      wait_cnt_q;
    logic                 timeout_q;

    logic [PtrW-1:0]          wr_ptr_q;
    logic [PtrW-1:0]          rd_ptr_q;
    logic [payload_width-1:0] pay_mem_q [fifo_depth];
    logic [tag_width-1:0]     tag_mem_q [fifo_depth];

    logic fifo_empty;
    logic fifo_full;
    logic accept;
    logic push;
    logic pop;

    // Full when the pointers differ only in their wrap bit.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                        (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

    // Space is reserved at accept, so a grant push can never overflow.
    assign issue_ready_o = (state_q == StIdle) && !fifo_full;
    assign accept        = issue_valid_i && issue_ready_o;
    assign push          = (state_q == StReq) && grant_i;
    assign pop           = !fifo_empty && m_ready_i;

    assign req_o          = req_q;
    assign busy_o         = req_q;
    assign wait_timeout_o = timeout_q;
    assign m_valid_o      = !fifo_empty;
    assign m_payload_o    = pay_mem_q[rd_ptr_q[AddrW-1:0]];
    assign m_tag_o        = tag_mem_q[rd_ptr_q[AddrW-1:0]];

    // Request FSM: accept a token, hold req until grant or flush; grant beats flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            tag_q      <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q    <= StReq;
                        req_q      <= 1'b1;
                        tag_q      <= issue_tag_i;
                        wait_cnt_q <= '0;
                    end
                end
                StReq: begin
                    if (grant_i) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                    end else begin
                        if (wait_cnt_q < WaitMax) begin
                            wait_cnt_q <= wait_cnt_q + CntW'(1);
                        end
                        // This cycle brings the wait count up to the limit.
                        if (wait_cnt_q >= WaitMax - CntW'(1)) begin
                            timeout_q <= 1'b1;
                        end
                        if (flush_i) begin
                            state_q <= StIdle;
                            req_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers; widths give natural wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    // FIFO storage, deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pay_mem_q[wr_ptr_q[AddrW-1:0]] <= payload_i;
            tag_mem_q[wr_ptr_q[AddrW-1:0]] <= tag_q;
        end
    end

endmodule

// File: tb/tb_req_grant_requester.sv
// Bench for req_grant_requester: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model built on queues.
module tb_req_grant_requester;

    localparam int unsigned Depth = 4;
    localparam int unsigned Tmo   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [3:0]  issue_tag;
    logic        issue_ready;
    logic        flush;
    logic        req;
    logic        grant;
    logic [31:0] payload;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_payload;
    logic [3:0]  m_tag;
    logic        busy;
    logic        wait_timeout;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          mo;       // request outstanding
    logic [3:0]  mtag;
    int          mwait;
    bit          mto;
    logic [31:0] qp[$];
    logic [3:0]  qt[$];

    req_grant_requester #(
        .payload_width (32),
        .tag_width     (4),
        .fifo_depth    (Depth),
        .timeout_cycles(Tmo)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .issue_valid_i (issue_valid),
        .issue_tag_i   (issue_tag),
        .issue_ready_o (issue_ready),
        .flush_i       (flush),
        .req_o         (req),
        .grant_i       (grant),
        .payload_i     (payload),
        .m_valid_o     (m_valid),
        .m_ready_i     (m_ready),
        .m_payload_o   (m_payload),
        .m_tag_o       (m_tag),
        .busy_o        (busy),
        .wait_timeout_o(wait_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mo    = 1'b0;
        mtag  = '0;
        mwait = 0;
        mto   = 1'b0;
        qp.delete();
        qt.delete();
    endtask

    task automatic check_outputs();
        bit exp_valid;
        exp_valid = (qp.size() > 0);
        check("req", 64'(req), 64'(mo));
        check("busy", 64'(busy), 64'(mo));
        check("issue_ready", 64'(issue_ready), 64'(!mo && qp.size() < Depth));
        check("m_valid", 64'(m_valid), 64'(exp_valid));
        check("wait_timeout", 64'(wait_timeout), 64'(mto));
        if (exp_valid) begin
            check("m_payload", 64'(m_payload), 64'(qp[0]));
            check("m_tag", 64'(m_tag), 64'(qt[0]));
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit pop;
        bit acc;
        if (rst) begin
            model_reset();
            return;
        end
        pop = (qp.size() > 0) && m_ready;
        acc = !mo && (qp.size() < Depth) && issue_valid;
        if (pop) begin
            void'(qp.pop_front());
            void'(qt.pop_front());
        end
        if (mo) begin
            if (grant) begin
                qp.push_back(payload);
                qt.push_back(mtag);
                mo = 1'b0;
            end else begin
                if (mwait < Tmo) mwait++;
                if (mwait >= Tmo) mto = 1'b1;
                if (flush) mo = 1'b0;
            end
        end else if (acc) begin
            mo    = 1'b1;
            mtag  = issue_tag;
            mwait = 0;
        end
    endtask

    task automatic cycle();
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        issue_valid = 1'b0;
        issue_tag   = '0;
        flush       = 1'b0;
        grant       = 1'b0;
        payload     = '0;
        m_ready     = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;

        // Zero-wait grant
        grant = 1'b1; payload = 32'h7C0;
        issue_valid = 1'b1; issue_tag = 4'd3; cycle();
        issue_valid = 1'b0; cycle();
        cycle();
        m_ready = 1'b1; cycle();
        m_ready = 1'b0; cycle();

        // Delayed grant: three wait cycles
        grant = 1'b0; payload = 32'h123;
        issue_valid = 1'b1; issue_tag = 4'd5; cycle();
        issue_valid = 1'b0;
        repeat (3) cycle();
        grant = 1'b1; cycle();
        grant = 1'b0; m_ready = 1'b1; cycle();
        m_ready = 1'b0; cycle();

        // Backpressure: five offers into a four-entry FIFO
        grant = 1'b1;
        for (int k = 0; k < 5; k++) begin
            issue_valid = 1'b1; issue_tag = 4'(k + 1); payload = 32'h7C0 + 32'(4 * k);
            cycle();
            issue_valid = 1'b0;
            cycle();
        end
        grant = 1'b0; m_ready = 1'b1;
        repeat (5) cycle();
        m_ready = 1'b0;

        // Flush without grant, then flush together with grant
        issue_valid = 1'b1; issue_tag = 4'd7; cycle();
        issue_valid = 1'b0; cycle();
        flush = 1'b1; cycle();
        flush = 1'b0; cycle();
        issue_valid = 1'b1; issue_tag = 4'd8; cycle();
        issue_valid = 1'b0; flush = 1'b1; grant = 1'b1; payload = 32'hABC; cycle();
        flush = 1'b0; grant = 1'b0; m_ready = 1'b1; cycle();
        m_ready = 1'b0; cycle();

        // Timeout: 19 ungranted request cycles, grant on the 20th
        issue_valid = 1'b1; issue_tag = 4'd9; cycle();
        issue_valid = 1'b0;
        repeat (19) cycle();
        grant = 1'b1; payload = 32'hBEEF; cycle();
        grant = 1'b0; m_ready = 1'b1; cycle();
        m_ready = 1'b0;
        repeat (3) cycle();

        // Reset with two entries queued and a request outstanding
        grant = 1'b1;
        for (int k = 0; k < 2; k++) begin
            issue_valid = 1'b1; issue_tag = 4'(10 + k); payload = 32'h500 + 32'(k);
            cycle();
            issue_valid = 1'b0;
            cycle();
        end
        grant = 1'b0;
        issue_valid = 1'b1; issue_tag = 4'd12; cycle();
        issue_valid = 1'b0; cycle();
        rst = 1'b1; cycle();
        rst = 1'b0; cycle();

        // Random traffic; exercises pointer wrap and rare resets
        for (int i = 0; i < 800; i++) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_tag   = 4'($urandom);
            grant       = ($urandom_range(0, 9) < 4);
            flush       = ($urandom_range(0, 9) == 0);
            payload     = $urandom;
            m_ready     = ($urandom_range(0, 1) == 1);
            rst         = ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst = 1'b0; issue_valid = 1'b0; grant = 1'b0; flush = 1'b0; m_ready = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
